time_set_ctrl: RTL and testbench

- Push-button time-setting front end that sits directly upstream of the RTC and drives its initial_time_hh / initial_time_mm / initial_time_valid inputs.
- Debounces three raw buttons (mode, increment, decrement) and runs an edit FSM (hours, then minutes) seeded from the RTC's current time.
- On completion, issues a one-cycle load pulse to the RTC.
- Also exports an edit-state indicator so the display path can mark the field being edited.

---
 rtl/time_set_ctrl.sv | 145 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Push-button time-setting front end: debounces mode/inc/dec buttons and edits
// hours then minutes, issuing a one-cycle load strobe to the RTC on commit.
module time_set_ctrl #(
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hh,
    input  logic [5:0] cur_mm,
    output logic [4:0] initial_time_hh,
    output logic [5:0] initial_time_mm,
    output logic       initial_time_valid,
    output logic [1:0] setting
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SET_HH = 2'b01,
        SET_MM = 2'b10,
        COMMIT = 2'b11
    } state_t;

    state_t        state;
    logic [2:0]    raw;
    logic [2:0]    sync1, sync2, deb, deb_d, press;
    logic [DW-1:0] deb_cnt [3];
    logic [TW-1:0] tmo_cnt;
    logic [4:0]    edit_hh;
    logic [5:0]    edit_mm;
    logic          p_mode, p_inc, p_dec;

    assign raw    = {btn_dec, btn_inc, btn_mode};
    assign p_mode = press[0];
    assign p_inc  = press[1];
    assign p_dec  = press[2];

    // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            setting            <= 2'b00;
            edit_hh            <= '0;
            edit_mm            <= '0;
            initial_time_hh    <= '0;
            initial_time_mm    <= '0;
            initial_time_valid <= 1'b0;
            tmo_cnt            <= '0;
        end else begin
            initial_time_hh    <= edit_hh;
            initial_time_mm    <= edit_mm;
            initial_time_valid <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (p_mode) begin
                        state   <= SET_HH;
                        setting <= SET_HH;
                        edit_hh <= (cur_hh > 5'd23) ? '0 : cur_hh;
                        edit_mm <= (cur_mm > 6'd59) ? '0 : cur_mm;
                    end
                end
                SET_HH: begin
                    if (p_mode) begin
                        state   <= SET_MM;
                        setting <= SET_MM;
                        tmo_cnt <= '0;
                    end else if (p_inc || p_dec) begin
                        tmo_cnt <= '0;
                        if (p_inc && !p_dec)
                            edit_hh <= (edit_hh == 5'd23) ? '0 : edit_hh + 5'd1;
                        else if (p_dec && !p_inc)
                            edit_hh <= (edit_hh == 5'd0) ? 5'd23 : edit_hh - 5'd1;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= IDLE;
                        setting <= IDLE;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                SET_MM: begin
                    if (p_mode) begin
                        state              <= COMMIT;
                        setting            <= COMMIT;
                        initial_time_valid <= 1'b1;
                        tmo_cnt            <= '0;
                    end else if (p_inc || p_dec) begin
                        tmo_cnt <= '0;
                        if (p_inc && !p_dec)
                            edit_mm <= (edit_mm == 6'd59) ? '0 : edit_mm + 6'd1;
                        else if (p_dec && !p_inc)
                            edit_mm <= (edit_mm == 6'd0) ? 6'd59 : edit_mm - 6'd1;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= IDLE;
                        setting <= IDLE;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                COMMIT: begin
                    state   <= IDLE;
                    setting <= IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: commits are queued when the final mode
// press is issued and compared when the load strobe appears.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_dec;
    logic [4:0] cur_hh;
    logic [5:0] cur_mm;
    logic [4:0] initial_time_hh;
    logic [5:0] initial_time_mm;
    logic       initial_time_valid;
    logic [1:0] setting;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [10:0] sb[$];

    time_set_ctrl #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .btn_mode           (btn_mode),
        .btn_inc            (btn_inc),
        .btn_dec            (btn_dec),
        .cur_hh             (cur_hh),
        .cur_mm             (cur_mm),
        .initial_time_hh    (initial_time_hh),
        .initial_time_mm    (initial_time_mm),
        .initial_time_valid (initial_time_valid),
        .setting            (setting)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        repeat (10) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each strobe cycle must match the next queued commit.
    always @(negedge clk) begin
        if (rst_n && initial_time_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                logic [10:0] e;
                e = sb.pop_front();
                chk("commit_hh", initial_time_hh, e[10:6]);
                chk("commit_mm", initial_time_mm, e[5:0]);
                chk("commit_setting", setting, 3);
            end
        end
    end

    initial begin
        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_hh = 5'd0; cur_mm = 6'd0;
        idle(3);
        chk("rst_hh", initial_time_hh, 0);
        chk("rst_mm", initial_time_mm, 0);
        chk("rst_valid", initial_time_valid, 0);
        chk("rst_setting", setting, 0);
        rst_n = 1'b1;
        idle(3);

        // 1: a 3-cycle glitch is filtered, a held press lands after DEB+2 (+1 for the FSM)
        btn_mode = 1'b1;
        idle(3);
        btn_mode = 1'b0;
        idle(12);
        chk("glitch_setting", setting, 0);
        btn_mode = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1 chk("latency_before", setting, 0);
        @(posedge clk);
        #1 chk("latency_at", setting, 1);
        idle(3);
        btn_mode = 1'b0;
        idle(10);
        sb.push_back({5'd0, 6'd0});
        press(1, 0, 0);
        chk("t1_to_mm", setting, 2);
        press(1, 0, 0);
        chk("t1_idle", setting, 0);

        // 2: full set with wrap
        cur_hh = 5'd23; cur_mm = 6'd58;
        press(1, 0, 0);
        chk("t2_setting_hh", setting, 1);
        chk("t2_load_hh", initial_time_hh, 23);
        chk("t2_load_mm", initial_time_mm, 58);
        press(0, 1, 0);
        chk("t2_hh_wrap", initial_time_hh, 0);
        press(1, 0, 0);
        chk("t2_setting_mm", setting, 2);
        press(0, 1, 0);
        chk("t2_mm_59", initial_time_mm, 59);
        press(0, 1, 0);
        chk("t2_mm_wrap", initial_time_mm, 0);
        sb.push_back({5'd0, 6'd0});
        press(1, 0, 0);
        chk("t2_idle", setting, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // 3: decrement wrap
        cur_hh = 5'd0; cur_mm = 6'd0;
        press(1, 0, 0);
        press(0, 0, 1);
        chk("t3_hh_wrap", initial_time_hh, 23);
        press(1, 0, 0);
        press(0, 0, 1);
        chk("t3_mm_wrap", initial_time_mm, 59);
        sb.push_back({5'd23, 6'd59});
        press(1, 0, 0);
        chk("t3_idle", setting, 0);
        chk("t3_sb_empty", sb.size(), 0);

        // 4: timeout abandons the edit, re-entry reloads from current time
        cur_hh = 5'd10; cur_mm = 6'd20;
        press(1, 0, 0);
        press(0, 1, 0);
        chk("t4_hh_inc", initial_time_hh, 11);
        idle(30);
        chk("t4_still_editing", setting, 1);
        idle(40);
        chk("t4_timed_out", setting, 0);
        chk("t4_hold_hh", initial_time_hh, 11);
        cur_hh = 5'd5; cur_mm = 6'd7;
        press(1, 0, 0);
        chk("t4_reload_setting", setting, 1);
        chk("t4_reload_hh", initial_time_hh, 5);
        chk("t4_reload_mm", initial_time_mm, 7);

        // 5: simultaneous events
        press(0, 1, 1);
        chk("t5_incdec_hh", initial_time_hh, 5);
        chk("t5_incdec_setting", setting, 1);
        press(1, 1, 0);
        chk("t5_modeinc_setting", setting, 2);
        chk("t5_modeinc_hh", initial_time_hh, 5);
        chk("t5_modeinc_mm", initial_time_mm, 7);
        sb.push_back({5'd5, 6'd7});
        press(1, 0, 0);
        chk("t5_sb_empty", sb.size(), 0);

        // 6: mid-edit reset, then clamp out-of-range current time
        cur_hh = 5'd1; cur_mm = 6'd2;
        press(1, 0, 0);
        press(1, 0, 0);
        chk("t6_in_mm", setting, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_setting", setting, 0);
        chk("t6_rst_hh", initial_time_hh, 0);
        chk("t6_rst_mm", initial_time_mm, 0);
        chk("t6_rst_valid", initial_time_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);
        cur_hh = 5'd30; cur_mm = 6'd63;
        press(1, 0, 0);
        chk("t6_clamp_setting", setting, 1);
        chk("t6_clamp_hh", initial_time_hh, 0);
        chk("t6_clamp_mm", initial_time_mm, 0);
        press(1, 0, 0);
        sb.push_back({5'd0, 6'd0});
        press(1, 0, 0);
        chk("t6_idle", setting, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
